// File: rtl/mem_req_ctrl.sv
// Memory-stage request controller: turns a load/store held in the memory stage into a
// single SRAM-like transaction and handles pipeline flushes around the outstanding access.
module mem_req_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  input  logic        ms_load,
  input  logic        ms_store,
  input  logic        ms_ex,
  input  logic [3:0]  ms_lsV,
  input  logic [31:0] ms_addr,
  input  logic [31:0] ms_wdata,
  input  logic        refresh,
  input  logic        out_allow,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        ec_data_ok,
  output logic [31:0] ec_data_rdata,
  output logic        stall_req
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} state_t;

  state_t     state;
  logic       flush_seen;
  logic       lsv_legal;
  logic [1:0] lsv_size;
  logic       start;

  // Only naturally aligned byte, half and word enables map onto an access size.
  always_comb begin
    lsv_legal = 1'b0;
    lsv_size  = 2'd0;
    case (ms_lsV)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        lsv_legal = 1'b1;
        lsv_size  = 2'd0;
      end
      4'b0011, 4'b1100: begin
        lsv_legal = 1'b1;
        lsv_size  = 2'd1;
      end
      4'b1111: begin
        lsv_legal = 1'b1;
        lsv_size  = 2'd2;
      end
      default: begin
        lsv_legal = 1'b0;
        lsv_size  = 2'd0;
      end
    endcase
  end

  assign start = (state == IDLE) & ms_valid & (ms_load | ms_store) & ~ms_ex & lsv_legal & ~refresh;

  assign stall_req = start | (state == REQ) | (state == WAIT) | (state == DISCARD);

  // A flush cannot withdraw a request already on the bus, so it is remembered until
  // addr_ok and the accepted transaction is then drained and dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      flush_seen    <= 1'b0;
      data_req      <= 1'b0;
      data_wr       <= 1'b0;
      data_size     <= 2'd0;
      data_addr     <= 32'd0;
      data_wdata    <= 32'd0;
      ec_data_ok    <= 1'b0;
      ec_data_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            flush_seen <= 1'b0;
            data_req   <= 1'b1;
            data_wr    <= ms_store;
            data_size  <= lsv_size;
            data_addr  <= ms_addr;
            data_wdata <= ms_wdata;
          end
        end
        REQ: begin
          if (refresh) flush_seen <= 1'b1;
          if (data_addr_ok) begin
            data_req   <= 1'b0;
            flush_seen <= 1'b0;
            state      <= (refresh | flush_seen) ? DISCARD : WAIT;
          end
        end
        WAIT: begin
          if (refresh) begin
            state <= data_data_ok ? IDLE : DISCARD;
          end else if (data_data_ok) begin
            state         <= DONE;
            ec_data_ok    <= 1'b1;
            ec_data_rdata <= data_wr ? 32'd0 : data_rdata;
          end
        end
        DISCARD: begin
          if (data_data_ok) state <= IDLE;
        end
        DONE: begin
          if (out_allow | refresh) begin
            state      <= IDLE;
            ec_data_ok <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios plus randomized transactions
// whose expected bus and result behaviour is derived per transaction from the access rules.
module tb_mem_req_ctrl;

  logic        clk;
  logic        reset;
  logic        ms_valid, ms_load, ms_store, ms_ex;
  logic [3:0]  ms_lsV;
  logic [31:0] ms_addr, ms_wdata;
  logic        refresh, out_allow;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        ec_data_ok;
  logic [31:0] ec_data_rdata;
  logic        stall_req;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  mem_req_ctrl dut (
    .clk(clk), .reset(reset),
    .ms_valid(ms_valid), .ms_load(ms_load), .ms_store(ms_store), .ms_ex(ms_ex),
    .ms_lsV(ms_lsV), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
    .refresh(refresh), .out_allow(out_allow),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ec_data_ok(ec_data_ok), .ec_data_rdata(ec_data_rdata), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ms_valid = 0; ms_load = 0; ms_store = 0; ms_ex = 0;
    ms_lsV = 4'd0; ms_addr = 32'd0; ms_wdata = 32'd0;
    refresh = 0; out_allow = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'd0;
  endtask

  task automatic applyStimulus(input bit st, input logic [3:0] lsv, input bit ex,
                               input logic [31:0] addr, input logic [31:0] wdata);
    ms_valid = 1; ms_load = !st; ms_store = st; ms_ex = ex;
    ms_lsV = lsv; ms_addr = addr; ms_wdata = wdata;
  endtask

  // Reference rules: aligned byte/half/word enables only; size follows enabled byte count.
  function automatic bit legal_lsv(input logic [3:0] v);
    return v inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  function automatic logic [1:0] size_of(input logic [3:0] v);
    case ($countones(v))
      1:       return 2'd0;
      2:       return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] pick_legal();
    logic [3:0] tbl [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    return tbl[$urandom_range(0, 6)];
  endfunction

  // fmode: 0 none, 1 refresh in REQ at cycle fat, 2 refresh after addr_ok at cycle fat, 3 refresh leaves DONE
  task automatic run_txn(input string tag, input bit st, input logic [3:0] lsv, input bit ex,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int addr_dly, input int data_dly, input int fmode, input int fat,
                         input int hold, input logic [31:0] fixed_rd);
    bit issue;
    bit flushed;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    issue   = legal_lsv(lsv) && !ex;
    flushed = 0;
    exp_rd  = 32'd0;
    applyStimulus(st, lsv, ex, addr, wdata);
    refresh = 0; out_allow = 0;
    #1;
    checkOutput({tag, ".start_stall"}, stall_req, issue);
    checkOutput({tag, ".start_noreq"}, data_req, 0);
    tick();
    ms_valid = 0; ms_ex = 0;
    ms_lsV = 4'($urandom); ms_addr = $urandom; ms_wdata = $urandom;
    if (!issue) begin
      #1;
      checkOutput({tag, ".noissue_req"}, data_req, 0);
      checkOutput({tag, ".noissue_stall"}, stall_req, 0);
      checkOutput({tag, ".noissue_ecok"}, ec_data_ok, 0);
      return;
    end
    for (int c = 0; c <= addr_dly; c++) begin
      data_addr_ok = (c == addr_dly);
      refresh      = (fmode == 1 && c == fat);
      data_data_ok = 1'($urandom_range(0, 1));
      #1;
      checkOutput({tag, ".req"}, data_req, 1);
      checkOutput({tag, ".wr"}, data_wr, st);
      checkOutput({tag, ".size"}, data_size, size_of(lsv));
      checkOutput({tag, ".addr"}, data_addr, addr);
      checkOutput({tag, ".wdata"}, data_wdata, wdata);
      checkOutput({tag, ".req_stall"}, stall_req, 1);
      if (refresh) flushed = 1;
      tick();
    end
    data_addr_ok = 0; refresh = 0; data_data_ok = 0;
    for (int c = 0; c <= data_dly; c++) begin
      data_data_ok = (c == data_dly);
      rd = (fixed_rd != 0) ? fixed_rd : $urandom;
      data_rdata = rd;
      refresh = (fmode == 2 && c == fat);
      #1;
      checkOutput({tag, ".wait_stall"}, stall_req, 1);
      checkOutput({tag, ".wait_noreq"}, data_req, 0);
      checkOutput({tag, ".wait_ecok"}, ec_data_ok, 0);
      if (refresh) flushed = 1;
      if (c == data_dly) exp_rd = st ? 32'd0 : rd;
      tick();
    end
    data_data_ok = 0; refresh = 0; data_rdata = $urandom;
    if (flushed) begin
      #1;
      checkOutput({tag, ".drop_ecok"}, ec_data_ok, 0);
      checkOutput({tag, ".drop_stall"}, stall_req, 0);
      checkOutput({tag, ".drop_req"}, data_req, 0);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if ($urandom_range(0, 1) == 1) applyStimulus(0, pick_legal(), 0, $urandom, $urandom);
      #1;
      checkOutput({tag, ".done_ecok"}, ec_data_ok, 1);
      checkOutput({tag, ".done_rdata"}, ec_data_rdata, exp_rd);
      checkOutput({tag, ".done_stall"}, stall_req, 0);
      checkOutput({tag, ".done_noreq"}, data_req, 0);
      tick();
    end
    ms_valid = 0;
    if (fmode == 3) refresh = 1; else out_allow = 1;
    #1;
    checkOutput({tag, ".rel_ecok"}, ec_data_ok, 1);
    checkOutput({tag, ".rel_rdata"}, ec_data_rdata, exp_rd);
    tick();
    out_allow = 0; refresh = 0;
    #1;
    checkOutput({tag, ".after_ecok"}, ec_data_ok, 0);
    checkOutput({tag, ".after_stall"}, stall_req, 0);
    checkOutput({tag, ".after_req"}, data_req, 0);
  endtask

  initial begin
    bit st;
    logic [3:0] lsv;
    int ad, dd, fm, fa;
    reset = 1;
    idle_inputs();
    tick();
    tick();
    checkOutput("rst.req", data_req, 0);
    checkOutput("rst.wr", data_wr, 0);
    checkOutput("rst.size", data_size, 0);
    checkOutput("rst.addr", data_addr, 0);
    checkOutput("rst.wdata", data_wdata, 0);
    checkOutput("rst.ecok", ec_data_ok, 0);
    checkOutput("rst.ecrdata", ec_data_rdata, 0);
    checkOutput("rst.stall", stall_req, 0);
    reset = 0;
    tick();

    run_txn("ldw", 0, 4'b1111, 0, 32'h8000_0010, 32'h0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    run_txn("sth", 1, 4'b1100, 0, 32'h0000_1002, 32'hABCD_0000, 3, 0, 0, 0, 1, 32'h0);
    run_txn("flush_wait", 0, 4'b0001, 0, 32'h0000_2003, 32'h0, 0, 2, 2, 0, 1, 32'h0);
    run_txn("after_drain", 0, 4'b0011, 0, 32'h0000_2004, 32'h0, 0, 0, 0, 0, 1, 32'h0);
    run_txn("flush_req", 0, 4'b1111, 0, 32'h0000_3000, 32'h0, 2, 1, 1, 0, 1, 32'h0);
    run_txn("flush_coinc", 0, 4'b1000, 0, 32'h0000_3007, 32'h0, 0, 1, 2, 1, 1, 32'h0);
    run_txn("done_hold", 0, 4'b0100, 0, 32'h0000_4002, 32'h0, 1, 1, 0, 0, 3, 32'h1234_5678);
    run_txn("done_flush", 1, 4'b0010, 0, 32'h0000_4001, 32'h0000_5500, 0, 0, 3, 0, 2, 32'h0);
    run_txn("ex", 0, 4'b1111, 1, 32'h0000_5000, 32'h0, 0, 0, 0, 0, 1, 32'h0);
    run_txn("bad_lsv", 1, 4'b0101, 0, 32'h0000_5004, 32'h0, 0, 0, 0, 0, 1, 32'h0);

    // Reset in WAIT: the late data_ok must land in IDLE and be ignored.
    applyStimulus(0, 4'b1111, 0, 32'h0000_6000, 32'h0);
    #1;
    tick();
    ms_valid = 0;
    data_addr_ok = 1;
    #1;
    checkOutput("rstw.req", data_req, 1);
    tick();
    data_addr_ok = 0;
    reset = 1;
    #1;
    checkOutput("rstw.wait_stall", stall_req, 1);
    tick();
    reset = 0;
    #1;
    checkOutput("rstw.req0", data_req, 0);
    checkOutput("rstw.addr0", data_addr, 0);
    checkOutput("rstw.size0", data_size, 0);
    checkOutput("rstw.stall0", stall_req, 0);
    tick();
    data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
    #1;
    checkOutput("rstw.late_stall", stall_req, 0);
    tick();
    data_data_ok = 0;
    #1;
    checkOutput("rstw.late_ecok", ec_data_ok, 0);
    checkOutput("rstw.late_ecrdata", ec_data_rdata, 0);
    checkOutput("rstw.late_req", data_req, 0);

    for (int n = 0; n < 40; n++) begin
      st  = 1'($urandom_range(0, 1));
      lsv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pick_legal();
      ad  = $urandom_range(0, 3);
      dd  = $urandom_range(0, 3);
      fm  = $urandom_range(0, 3);
      fa  = (fm == 1) ? $urandom_range(0, ad) : (fm == 2) ? $urandom_range(0, dd) : 0;
      run_txn($sformatf("rnd%0d", n), st, lsv, ($urandom_range(0, 7) == 0),
              $urandom, $urandom, ad, dd, fm, fa, $urandom_range(0, 3), 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports, clock and reset first: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-003 SHALL have ports: ms_valid  in  1  stage holds valid instr; ms_load  in  1  load; ms_store  in  1  store; ms_ex  in  1  instr raised exception, suppress access.
REQ-004 SHALL have ports: ms_lsV  in  4  byte enables; ms_addr  in  32  byte address; ms_wdata  in  32  store data, lane-aligned.
REQ-005 SHALL have ports: refresh  in  1  pipeline flush; out_allow  in  1  next stage accepts this cycle.
REQ-006 SHALL have ports: data_req  out  1; data_wr  out  1; data_size  out  2; data_addr  out  32; data_wdata  out  32 (SRAM-like request channel).
REQ-007 SHALL have ports: data_addr_ok  in  1; data_data_ok  in  1; data_rdata  in  32 (SRAM-like responses).
REQ-008 SHALL have ports: ec_data_ok  out  1  access complete, result valid; ec_data_rdata  out  32  captured read data; stall_req  out  1  hold the stage.

Function
REQ-009 SHALL implement states IDLE, REQ, WAIT, DONE, DISCARD; all outputs except stall_req registered.
REQ-010 start = IDLE & ms_valid & (ms_load|ms_store) & !ms_ex & legal ms_lsV & !refresh; legal lsV = 0001,0010,0100,1000,0011,1100,1111.
REQ-011 Illegal lsV or ms_ex SHALL issue no request and leave the FSM in IDLE.
REQ-012 IDLE & start -> REQ next cycle; latch data_wr=ms_store, data_addr=ms_addr, data_wdata=ms_wdata, data_size = 0 for one-hot lsV, 1 for 0011/1100, 2 for 1111.
REQ-013 data_req SHALL be 1 only in REQ; data_wr/size/addr/wdata SHALL stay constant from REQ entry until data_addr_ok.
REQ-014 REQ & data_addr_ok -> WAIT; REQ & data_addr_ok & refresh (or refresh seen earlier while in REQ) -> DISCARD; a request is never withdrawn before addr_ok.
REQ-015 data_data_ok SHALL be honoured only in WAIT or DISCARD; ignored in all other states.
REQ-016 WAIT & data_data_ok & !refresh -> DONE; ec_data_rdata <= data_rdata for loads, 32'b0 for stores; ec_data_ok <= 1.
REQ-017 WAIT & refresh & !data_data_ok -> DISCARD; WAIT & refresh & data_data_ok -> IDLE, response dropped, ec_data_ok stays 0.
REQ-018 DISCARD & data_data_ok -> IDLE, response dropped; refresh in DISCARD has no further effect.
REQ-019 DONE: ec_data_ok and ec_data_rdata held stable; out_allow -> IDLE with ec_data_ok <= 0; refresh -> IDLE with ec_data_ok <= 0.
REQ-020 stall_req = start | REQ | WAIT | DISCARD (combinational); 0 in DONE and idle-without-start.
REQ-021 At most one transaction outstanding; no new request SHALL issue until DISCARD drains.
REQ-022 Minimum latency: start cycle t, data_req at t+1; addr_ok at t+1, data_ok at t+2 -> ec_data_ok=1 at t+3.

Reset
REQ-023 reset SHALL force IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, ec_data_ok=0, ec_data_rdata=0 at the next edge, overriding all inputs.
REQ-024 Reset mid-transaction SHALL abandon it; a late data_data_ok after reset arrives in IDLE and is ignored.

Verification
REQ-025 Load word: lsV=1111, addr=0x8000_0010, addr_ok same cycle, data_ok 1 cycle later, rdata=0xDEADBEEF -> size=2, wr=0, ec_data_ok=1, ec_data_rdata=0xDEADBEEF at t+3.
REQ-026 Store half: lsV=1100, wdata=0xABCD_0000, addr_ok delayed 3 cycles -> req/addr/wdata/size=1/wr=1 stable 4 cycles, stall_req high throughout, ec_data_rdata=0.
REQ-027 Flush in WAIT: refresh 1 cycle after addr_ok, data_ok 2 cycles later -> DISCARD, stall_req high until data_ok, ec_data_ok never 1, next load issues only after drain.
REQ-028 Flush in REQ before addr_ok -> data_req held until addr_ok, then DISCARD; refresh coincident with data_ok in WAIT -> IDLE, ec_data_ok=0.
REQ-029 DONE with out_allow=0 for 3 cycles -> ec_data_ok/rdata held, stall_req=0, no new req; ms_ex=1 or lsV=0101 -> no data_req, stall_req=0.
REQ-030 Reset asserted in WAIT, data_ok one cycle after reset release -> all outputs zero, data_ok ignored, ec_data_ok=0.
